rca_word_sequencer: RTL
=======================

// Module: rca_word_sequencer
// PURPOSE
//  Multi-cycle wide adder built on one internal 4-bit ripple-carry slice with carry-in.
//  Captures WIDTH-bit operands and walks the slice over WIDTH/4 nibbles, one per cycle, LSB first.
//  Holds the inter-nibble carry in a register between cycles.
//  Sits between an operand producer and a result consumer; uses valid/ready handshakes on both sides.
// PARAMETERS
//  WIDTH    16   operand width in bits; must be a multiple of 4 and >= 4
//  NSLICE   WIDTH/4   derived local parameter; number of slice passes
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        operands a/b valid
//  in_ready   out  1        sequencer can accept operands
//  a          in   WIDTH    operand A
//  b          in   WIDTH    operand B
//  op_sub     in   1        1 = A-B (present only with RCA_SEQ_SUB_EN)
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  sum        out  WIDTH+1  result; sum[WIDTH] = final carry-out
//  busy       out  1        high in RUN or DONE
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, sum=0, busy=0,
//    carry=0, nibble index=0; operand registers cleared.
//  - FSM states IDLE, RUN, DONE:
//    IDLE: in_ready=1. On in_valid&in_ready, latch a, b (and op_sub), carry<=0, idx<=0, go to RUN.
//    RUN: each cycle sum[4*idx+:4] <= slice(a_nib, b_nib, carry); carry <= slice cout; idx++.
//      On the edge that processes idx==NSLICE-1, sum[WIDTH] <= cout and state goes to DONE.
//    DONE: out_valid=1, sum stable. On out_valid&out_ready, go to IDLE.
//  - Latency: out_valid rises exactly NSLICE cycles after the accept edge (4 cycles at WIDTH=16).
//  - Throughput: in_ready=0 in RUN and DONE. The minimum accept-to-accept interval is NSLICE+2
//    cycles (out_ready=1 at all times).
//  - Operand inputs are sampled only on the accept edge. Changes to a/b/op_sub during RUN/DONE
//    have no effect.
//  - sum: nibbles not yet written in RUN keep their previous value and are not observable as valid.
//    sum holds its value after DONE->IDLE until the next pass overwrites it.
//  - in_valid in RUN/DONE is ignored (not queued). out_ready outside DONE is ignored.
//  - WIDTH=4: a single RUN cycle; out_valid follows the accept edge after 1 cycle.
//  - Reset mid-RUN or mid-DONE: the in-flight operation is discarded and all outputs return to
//    reset values immediately. The first post-reset accept proceeds normally.
//  - Arithmetic: unsigned. sum = a + b, carry-out in sum[WIDTH]. No saturation or overflow flag.
// CONFIGURATION
//  RCA_SEQ_SUB_EN defined:
//    - op_sub port exists and is latched on accept.
//    - op_sub=1: each slice uses ~b nibble and the initial carry is 1 (two's complement A-B).
//      sum[WIDTH]=1 means no borrow (a>=b).
//    - op_sub=0: identical to add.
//  RCA_SEQ_SUB_EN undefined:
//    - No op_sub port. Add only; initial carry is always 0. No inverter logic.
// TESTING (WIDTH=16)
//  1. a=16'h1234, b=16'h4321, accept -> out_valid exactly 4 cycles later, sum=17'h05555.
//  2. a=16'hFFFF, b=16'h0001 -> sum=17'h10000. Checks carry propagation through all 4 passes.
//  3. Hold out_ready=0 for 5 cycles in DONE with in_valid=1, a=1, b=1:
//     -> sum and out_valid stable, in_ready=0, no second capture.
//     After out_ready=1, the first accept yields 17'h00002.
//  4. Drop rst_n at RUN idx=2 -> out_valid=0, in_ready=1, sum=0 asynchronously.
//     Then a=16'h0F0F, b=16'h00F1 -> 17'h01000.
//  5. RCA_SEQ_SUB_EN: a=7, b=5, op_sub=1 -> 17'h10002. a=5, b=7, op_sub=1 -> 17'h0FFFE.
//  6. in_valid held 1, out_ready held 1, 3 operand pairs -> accepts spaced exactly 6 cycles apart.
//     Results in order and correct; no lost or duplicated result.

Source files
------------

// File: rtl/rca_word_sequencer.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple-carry slice walked LSB-first over the operands.
// Define RCA_SEQ_SUB_EN to add the op_sub port (two's-complement A-B).
module rca4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[4];
endmodule

module rca_word_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef RCA_SEQ_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [IDXW-1:0]  idx_q;
  logic             sub_q;
  logic             accept, last;
  logic [3:0]       a_nib, b_nib, s_nib;
  logic             cout;

`ifdef RCA_SEQ_SUB_EN
  logic sub_in;
  assign sub_in = op_sub;
  assign b_nib  = b_q[4*idx_q +: 4] ^ {4{sub_q}};
`else
  logic sub_in;
  assign sub_in = 1'b0;
  assign b_nib  = b_q[4*idx_q +: 4];
`endif

  assign a_nib = a_q[4*idx_q +: 4];

  rca4_slice u_slice (.a(a_nib), .b(b_nib), .cin(carry_q), .s(s_nib), .cout(cout));

  assign accept = in_valid & in_ready;
  assign last   = (idx_q == IDXW'(NSLICE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = RUN;
      end
      RUN:  if (last) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Subtract starts with carry 1 so ~b + 1 forms the two's complement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum     <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      sub_q   <= sub_in;
      carry_q <= sub_in;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      sum[4*idx_q +: 4] <= s_nib;
      carry_q           <= cout;
      idx_q             <= idx_q + IDXW'(1);
      if (last) sum[WIDTH] <= cout;
    end
  end
endmodule
